sm_noc_ni: RTL and testbench
============================

// Module: sm_noc_ni
// PURPOSE
//  Per-CPU network interface between a schoolMIPS core's data bus and the mailbox router.
//  Core sends messages by writing memory-mapped registers; NI queues them in a TX FIFO.
//  Router writes happen via a req/ack handshake; NI polls the router for this CPU's mailbox
//  and holds a received message in an RX register until the core reads it.
// PARAMETERS
//  MY_ID       0   this CPU's id; used as router address for mailbox reads
//  CPU_N       4   number of CPUs on the router
//  ID_W        2   id width, equals clog2(CPU_N)
//  MSG_SIZE    32  message width, 1..32 bits
//  FIFO_DEPTH  4   TX FIFO entries, power of 2, >=2
//  POLL_DIV    16  idle cycles between mailbox polls, >=1
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous active-high reset
//  cpu_sel    in   1         bus select for NI register window
//  cpu_addr   in   2         word index: 0 TXDATA, 1 DEST, 2 RXDATA, 3 STATUS
//  cpu_we     in   1         write strobe, qualified by cpu_sel
//  cpu_wd     in   32        write data
//  cpu_rd     out  32        read data, combinational from cpu_addr
//  r_req      out  1         router request, held until r_ack
//  r_we       out  1         1 = write message, 0 = read own mailbox
//  r_addr     out  ID_W      destination id (write) or MY_ID (read)
//  r_wdata    out  MSG_SIZE  message to router
//  r_rdata    in   MSG_SIZE  mailbox content, valid with r_ack on read
//  r_rvalid   in   1         mailbox held a message, valid with r_ack on read
//  r_ack      in   1         one-cycle completion pulse from router
//  irq        out  1         message-pending interrupt (SM_NI_IRQ_EN only)
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, DEST=0, rx_valid=0, rx_data=0, ovf=0, poll counter=0.
//   r_req=0, r_we=0, r_addr=0, r_wdata=0, irq=0, cpu_rd=0.
//  Registers:
//   TXDATA write: push {DEST, cpu_wd[MSG_SIZE-1:0]}. If full: drop the word and set ovf (sticky).
//   DEST r/w: bits [ID_W-1:0]; upper bits are ignored on write and read as 0.
//   RXDATA read: returns rx_data zero-extended. Read with rx_valid=1 clears rx_valid next edge.
//    Read with rx_valid=0 returns stale data, no side effect.
//   STATUS read: [0] tx_empty, [1] tx_full, [2] rx_valid, [3] ovf, [7:4] tx_count, rest 0.
//    Write with bit3=1 clears ovf.
//  FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH. Count is tracked separately (0..DEPTH).
//   Push and pop in the same cycle: count unchanged. This is legal even when full, because the pop frees a slot first.
//  FSM: IDLE, TX, RX. r_* outputs are registered and stable while r_req=1.
//   IDLE->TX: FIFO non-empty, and (last_rx=1, or no RX is due). Drive r_we=1, FIFO head.
//   IDLE->RX: rx_valid=0 and poll counter hit POLL_DIV-1, and (last_rx=0, or FIFO empty). Drive r_we=0, r_addr=MY_ID.
//   TX->IDLE on r_ack: pop FIFO, last_rx<=0.
//   RX->IDLE on r_ack: if r_rvalid, rx_data<=r_rdata and rx_valid<=1. Set last_rx<=1, clear poll counter.
//   Poll counter increments in IDLE only while rx_valid=0, and saturates at POLL_DIV-1.
//  r_req drops the cycle after r_ack. The minimum gap between requests is 1 idle cycle.
//  r_ack outside TX/RX is ignored.
//  RX is never issued while rx_valid=1, so a router message cannot overwrite an unread rx_data.
//  Reset mid-transaction: r_req=0 next cycle, and the queued FIFO contents are lost.
// CONFIGURATION
//  SM_NI_IRQ_EN defined: irq = rx_valid & irq_en. STATUS bit8 is irq_en (r/w, reset 0).
//  SM_NI_IRQ_EN undefined: irq tied 0. STATUS bit8 reads 0 and writes to it are ignored.
// TESTING
//  DEST=2, write TXDATA=0xCAFE -> r_req=1, r_we=1, r_addr=2, r_wdata=0xCAFE. Ack -> tx_empty=1.
//  Push 5 words, no ack, DEPTH=4 -> tx_full=1, ovf=1, count=4. Acks return words 1-4 in order.
//  Idle, POLL_DIV=16 -> RX request on cycle 16 with r_addr=MY_ID.
//   Ack, r_rvalid=1, r_rdata=0x1234 -> STATUS[2]=1.
//   RXDATA read returns 0x1234 and clears rx_valid. No poll is issued while rx_valid=1.
//  FIFO non-empty with RX due -> TX and RX alternate. Push+pop same cycle when full -> count stays 4.
//  Assert rst during TX with r_req=1 -> next cycle r_req=0, tx_empty=1, DEST=0.
//  SM_NI_IRQ_EN: irq_en=1 and a message arrives -> irq=1. RXDATA read -> irq=0.
//   Without the macro, irq stays 0.

Source files
------------

// File: rtl/sm_noc_ni.sv
// Network interface between a schoolMIPS data bus and the mailbox router: TX FIFO,
// polled RX mailbox register, router req/ack FSM. Optional SM_NI_IRQ_EN adds irq/irq_en.
module sm_noc_ni #(
    parameter int MY_ID      = 0,
    parameter int CPU_N      = 4,
    parameter int ID_W       = 2,
    parameter int MSG_SIZE   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_DIV   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_sel,
    input  logic [1:0]          cpu_addr,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_wd,
    output logic [31:0]         cpu_rd,
    output logic                r_req,
    output logic                r_we,
    output logic [ID_W-1:0]     r_addr,
    output logic [MSG_SIZE-1:0] r_wdata,
    input  logic [MSG_SIZE-1:0] r_rdata,
    input  logic                r_rvalid,
    input  logic                r_ack,
    output logic                irq
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = ID_W + MSG_SIZE;
    localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_DIV - 1);
    localparam logic [ID_W-1:0]   MY_ADDR  = ID_W'(MY_ID % CPU_N);

    typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_RX} state_t;

    state_t              state_q;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ID_W-1:0]     dest_q;
    logic                rx_valid_q;
    logic [MSG_SIZE-1:0] rx_data_q;
    logic                ovf_q;
    logic [POLL_W-1:0]   poll_q;
    logic                last_rx_q;
    logic                irq_en_w;

    logic             tx_empty, tx_full, push_req, push_ok, pop, rd_rx, stat_wr;
    logic             rx_due, tx_go, rx_go;
    logic [ENT_W-1:0] head_w;
    logic [31:0]      count_ext, status_w;

    assign tx_empty = (count_q == '0);
    assign tx_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_req = cpu_sel && cpu_we && (cpu_addr == 2'd0);
    assign stat_wr  = cpu_sel && cpu_we && (cpu_addr == 2'd3);
    assign rd_rx    = cpu_sel && !cpu_we && (cpu_addr == 2'd2) && rx_valid_q;
    assign pop      = (state_q == ST_TX) && r_ack;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!tx_full || pop);
    assign head_w   = mem_q[rd_ptr_q];

    // RX and TX take turns when both are pending; last_rx_q remembers whose turn it was.
    assign rx_due = !rx_valid_q && (poll_q == POLL_MAX);
    assign tx_go  = !tx_empty && (last_rx_q || !rx_due);
    assign rx_go  = rx_due && (!last_rx_q || tx_empty);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {dest_q, cpu_wd[MSG_SIZE-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dest_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            ovf_q      <= 1'b0;
            poll_q     <= '0;
            last_rx_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_go) begin
                        state_q <= ST_TX;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= head_w[ENT_W-1 -: ID_W];
                        r_wdata <= head_w[MSG_SIZE-1:0];
                    end else if (rx_go) begin
                        state_q <= ST_RX;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= MY_ADDR;
                    end
                    if (!rx_valid_q && (poll_q != POLL_MAX))
                        poll_q <= poll_q + 1'b1;
                end
                ST_TX: begin
                    if (r_ack) begin
                        state_q   <= ST_IDLE;
                        r_req     <= 1'b0;
                        last_rx_q <= 1'b0;
                    end
                end
                ST_RX: begin
                    if (r_ack) begin
                        state_q   <= ST_IDLE;
                        r_req     <= 1'b0;
                        last_rx_q <= 1'b1;
                        poll_q    <= '0;
                        if (r_rvalid)
                            rx_data_q <= r_rdata;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase

            if ((state_q == ST_RX) && r_ack && r_rvalid)
                rx_valid_q <= 1'b1;
            else if (rd_rx)
                rx_valid_q <= 1'b0;

            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;

            if (push_req && !push_ok)
                ovf_q <= 1'b1;
            else if (stat_wr && cpu_wd[3])
                ovf_q <= 1'b0;

            if (cpu_sel && cpu_we && (cpu_addr == 2'd1))
                dest_q <= cpu_wd[ID_W-1:0];
        end
    end

`ifdef SM_NI_IRQ_EN
    logic irq_en_q;
    always_ff @(posedge clk) begin
        if (rst)
            irq_en_q <= 1'b0;
        else if (stat_wr)
            irq_en_q <= cpu_wd[8];
    end
    assign irq_en_w = irq_en_q;
    assign irq      = rx_valid_q & irq_en_q;
`else
    assign irq_en_w = 1'b0;
    assign irq      = 1'b0;
`endif

    assign count_ext = 32'(count_q);

    always_comb begin
        status_w      = '0;
        status_w[0]   = tx_empty;
        status_w[1]   = tx_full;
        status_w[2]   = rx_valid_q;
        status_w[3]   = ovf_q;
        status_w[7:4] = count_ext[3:0];
        status_w[8]   = irq_en_w;
    end

    always_comb begin
        cpu_rd = '0;
        if (cpu_sel) begin
            case (cpu_addr)
                2'd1:    cpu_rd[ID_W-1:0]     = dest_q;
                2'd2:    cpu_rd[MSG_SIZE-1:0] = rx_data_q;
                2'd3:    cpu_rd               = status_w;
                default: cpu_rd               = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_noc_ni.sv
// Self-checking bench for sm_noc_ni: directed literal checks followed by randomized bus and
// router traffic compared every cycle against a queue-based behavioural model.
module tb_sm_noc_ni;
    localparam int MY_ID = 1;
    localparam int DEPTH = 4;
    localparam int PD    = 16;
`ifdef SM_NI_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cpu_sel, cpu_we, r_req, r_we, r_rvalid, r_ack, irq;
    logic [1:0]  cpu_addr, r_addr;
    logic [31:0] cpu_wd, cpu_rd, r_wdata, r_rdata;

    int vectors = 0;
    int miscompares = 0;
    bit auto_ack = 1'b0;

    sm_noc_ni #(.MY_ID(MY_ID), .CPU_N(4), .ID_W(2), .MSG_SIZE(32),
                .FIFO_DEPTH(DEPTH), .POLL_DIV(PD)) dut (
        .clk(clk), .rst(rst), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .r_req(r_req), .r_we(r_we), .r_addr(r_addr),
        .r_wdata(r_wdata), .r_rdata(r_rdata), .r_rvalid(r_rvalid), .r_ack(r_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of pending messages plus the few pieces of state the rules name.
    typedef struct { logic [1:0] d; logic [31:0] m; } ent_t;
    ent_t        m_q[$];
    logic [1:0]  m_dest, m_addr;
    logic [31:0] m_rxd, m_wdata;
    bit          m_rxv, m_ovf, m_last, m_we, m_irqen, m_live = 1'b0;
    int          m_poll, m_busy;   // m_busy: 0 none, 1 sending, 2 polling

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_dest = 0; m_rxv = 0; m_rxd = 0; m_ovf = 0; m_poll = 0; m_last = 0;
                m_busy = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_irqen = 0; m_live = 1;
            end else begin
                bit empty0, rxv0, last0, due;
                int poll0, busy0;
                ent_t e;
                empty0 = (m_q.size() == 0);
                rxv0 = m_rxv; last0 = m_last; poll0 = m_poll; busy0 = m_busy;
                if (busy0 == 1 && r_ack) begin
                    $display("txn TX dest=%0d data=%08h", m_addr, m_wdata);
                    void'(m_q.pop_front());
                    m_last = 0; m_busy = 0;
                end else if (busy0 == 2 && r_ack) begin
                    $display("txn RX rvalid=%0b data=%08h", r_rvalid, r_rdata);
                    if (r_rvalid) begin m_rxv = 1; m_rxd = r_rdata; end
                    m_last = 1; m_poll = 0; m_busy = 0;
                end else if (busy0 == 0) begin
                    due = !rxv0 && (poll0 == PD - 1);
                    if (!empty0 && (last0 || !due)) begin
                        m_busy = 1; m_we = 1; m_addr = m_q[0].d; m_wdata = m_q[0].m;
                    end else if (due && (!last0 || empty0)) begin
                        m_busy = 2; m_we = 0; m_addr = 2'(MY_ID);
                    end
                    if (!rxv0 && poll0 < PD - 1) m_poll = poll0 + 1;
                end
                if (cpu_sel && cpu_we) begin
                    case (cpu_addr)
                        2'd0: if (m_q.size() < DEPTH) begin
                                  e.d = m_dest; e.m = cpu_wd; m_q.push_back(e);
                              end else m_ovf = 1;
                        2'd1: m_dest = cpu_wd[1:0];
                        2'd3: begin
                                  if (cpu_wd[3]) m_ovf = 0;
                                  if (IRQ_ON) m_irqen = cpu_wd[8];
                              end
                        default: ;
                    endcase
                end
                if (cpu_sel && !cpu_we && cpu_addr == 2'd2 && rxv0) m_rxv = 0;
            end
        end
    end

    function automatic logic [31:0] exp_rd();
        logic [31:0] s;
        s = '0;
        if (cpu_sel) begin
            case (cpu_addr)
                2'd1: s = {30'b0, m_dest};
                2'd2: s = m_rxd;
                2'd3: begin
                    s[0] = (m_q.size() == 0);
                    s[1] = (m_q.size() == DEPTH);
                    s[2] = m_rxv;
                    s[3] = m_ovf;
                    s[7:4] = 4'(m_q.size());
                    s[8] = m_irqen;
                end
                default: s = '0;
            endcase
        end
        return s;
    endfunction

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("r_req", {31'b0, r_req}, {31'b0, m_busy != 0});
                chk("r_we", {31'b0, r_we}, {31'b0, m_we});
                chk("r_addr", {30'b0, r_addr}, {30'b0, m_addr});
                chk("r_wdata", r_wdata, m_wdata);
                chk("cpu_rd", cpu_rd, exp_rd());
                chk("irq", {31'b0, irq}, {31'b0, m_rxv & m_irqen});
            end
        end
    end

    initial begin : router
        int dly = 0;
        forever begin
            @(posedge clk); #1;
            if (auto_ack) begin
                r_ack = 1'b0;
                if (r_req) begin
                    if (dly == 0) begin
                        r_ack = 1'b1;
                        r_rvalid = 1'($urandom_range(0, 1));
                        r_rdata = $urandom;
                        dly = $urandom_range(0, 3);
                    end else dly--;
                end else begin
                    r_ack = ($urandom_range(0, 15) == 0);
                end
            end
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cpu_sel = 1; cpu_we = 1; cpu_addr = a; cpu_wd = d;
        @(posedge clk); #1;
        cpu_sel = 0; cpu_we = 0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cpu_sel = 1; cpu_we = 0; cpu_addr = a;
        @(negedge clk);
        d = cpu_rd;
        @(posedge clk); #1;
        cpu_sel = 0;
    endtask

    task automatic ack(input logic v, input logic [31:0] d);
        @(posedge clk); #1;
        r_ack = 1; r_rvalid = v; r_rdata = d;
        @(posedge clk); #1;
        r_ack = 0; r_rvalid = 0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (r_req) begin ok = 1; break; end
        end
        if (!ok) chk("req_timeout", 32'd0, 32'd1);
    endtask

    // Acknowledge any mailbox polls (empty mailbox) until a message send is in flight.
    task automatic serve_until_tx();
        bit ok, found;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            wait_req(ok);
            if (!ok) break;
            if (r_we) begin found = 1; break; end
            ack(0, 0);
        end
        if (!found) chk("tx_not_issued", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
    endtask

    initial begin : stim
        logic [31:0] d;
        bit ok, seen;
        int n;
        rst = 1; cpu_sel = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
        r_ack = 0; r_rvalid = 0; r_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        cpu_read(2'd3, d);      chk("reset_status", d, 32'h1);
        cpu_write(2'd1, 32'hFFFF_FFFE);
        cpu_read(2'd1, d);      chk("dest_mask", d, 32'h2);
        cpu_write(2'd0, 32'hCAFE);
        wait_req(ok);
        chk("tx_we", {31'b0, r_we}, 32'd1);
        chk("tx_addr", {30'b0, r_addr}, 32'd2);
        chk("tx_data", r_wdata, 32'hCAFE);
        ack(0, 0);
        cpu_read(2'd3, d);      chk("tx_empty_after_ack", d & 32'h1, 32'h1);

        reset_pulse();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (r_req) begin n = i; break; end
        end
        chk("poll_cycle", n, 32'd16);
        chk("poll_we", {31'b0, r_we}, 32'd0);
        chk("poll_addr", {30'b0, r_addr}, MY_ID);
        cpu_write(2'd3, 32'h100);
        ack(1, 32'h1234);
        chk("irq_on_msg", {31'b0, irq}, {31'b0, IRQ_ON});
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (r_req) seen = 1;
        end
        chk("no_poll_while_rxv", {31'b0, seen}, 32'd0);
        cpu_read(2'd3, d);      chk("rx_valid_set", (d >> 2) & 32'h1, 32'h1);
        cpu_read(2'd2, d);      chk("rxdata", d, 32'h1234);
        chk("irq_after_read", {31'b0, irq}, 32'd0);
        cpu_read(2'd3, d);      chk("rx_valid_clr", (d >> 2) & 32'h1, 32'h0);

        reset_pulse();
        for (int i = 1; i <= 5; i++) cpu_write(2'd0, 32'h100 + i);
        cpu_read(2'd3, d);      chk("ovf_status", d, 32'h4A);
        for (int i = 1; i <= 4; i++) begin
            serve_until_tx();
            chk("fifo_order", r_wdata, 32'h100 + i);
            ack(0, 0);
        end
        cpu_write(2'd3, 32'h8);
        cpu_read(2'd3, d);      chk("ovf_clear", (d >> 3) & 32'h1, 32'h0);
        for (int i = 1; i <= 4; i++) cpu_write(2'd0, 32'h200 + i);
        serve_until_tx();
        cpu_read(2'd3, d);      chk("full_status", d, 32'h42);
        @(posedge clk); #1;
        r_ack = 1; cpu_sel = 1; cpu_we = 1; cpu_addr = 2'd0; cpu_wd = 32'h205;
        @(posedge clk); #1;
        r_ack = 0; cpu_sel = 0; cpu_we = 0;
        cpu_read(2'd3, d);      chk("push_pop_full", d, 32'h42);

        serve_until_tx();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_drops_req", {31'b0, r_req}, 32'd0);
        cpu_read(2'd3, d);      chk("rst_tx_empty", d, 32'h1);
        cpu_read(2'd1, d);      chk("rst_dest", d, 32'h0);

        auto_ack = 1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 599) == 0);
            cpu_sel  = ($urandom_range(0, 1) == 1);
            cpu_we   = ($urandom_range(0, 9) < 6);
            cpu_addr = 2'($urandom_range(0, 3));
            cpu_wd   = $urandom;
        end
        @(posedge clk); #1;
        rst = 0; cpu_sel = 0; cpu_we = 0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
